// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_fifo
// UART peripheral: TX/RX FIFOs, runtime parity, 1/2 stop bits, sticky errors, level IRQ.
// Rev    : 1.0
// ============================================================================
module uart_fifo #(
  parameter logic [15:0] BAUD_DEFAULT = 16'h1B8,
  parameter int          TX_DEPTH     = 8,
  parameter int          RX_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_o,
  output logic        tx_pin,
  input  logic        rx_pin
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  localparam logic [7:0] c_addr_ctrl   = 8'h00;
  localparam logic [7:0] c_addr_status = 8'h04;
  localparam logic [7:0] c_addr_baud   = 8'h08;
  localparam logic [7:0] c_addr_txdata = 8'h0C;
  localparam logic [7:0] c_addr_rxdata = 8'h10;
  localparam logic [7:0] c_addr_level  = 8'h14;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;

  logic [7:0]  w_addr;
  logic [6:0]  r_ctrl;
  logic [15:0] r_baud;
  logic        r_perr, r_ferr, r_ovr, r_irq;
  logic        w_tx_en, w_rx_en, w_par_en, w_par_odd;
  logic [2:0]  w_clr;

  assign w_addr    = addr_i[7:0];
  assign w_tx_en   = r_ctrl[0];
  assign w_rx_en   = r_ctrl[1];
  assign w_par_en  = r_ctrl[2] ^ r_ctrl[3];
  assign w_par_odd = (r_ctrl[3:2] == 2'b10);
  assign w_clr     = (we_i && w_addr == c_addr_status) ? data_i[6:4] : 3'b000;

  // ---------------- TX FIFO ----------------
  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wp, r_tx_rp;
  logic [TX_AW:0] r_tx_cnt;
  logic           w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [7:0]     w_tx_head;

  assign w_tx_full  = (r_tx_cnt == (TX_AW+1)'(TX_DEPTH));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_push  = we_i && (w_addr == c_addr_txdata) && w_tx_en && !w_tx_full;
  assign w_tx_head  = r_tx_mem[r_tx_rp];

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= data_i[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + TX_AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_AW'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + (TX_AW+1)'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - (TX_AW+1)'(1);
    end
  end

  // ---------------- TX FSM ----------------
  logic [2:0]  r_tx_state;
  logic [15:0] r_tx_tmr, r_tx_period;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_tx_par_bit, r_tx_par_en, r_tx_two_stop, r_tx_stop2, r_tx_pin;
  logic        w_tx_frame_end;

  assign w_tx_frame_end = (r_tx_state == c_st_stop) && (r_tx_tmr == 16'd0) &&
                          (!r_tx_two_stop || r_tx_stop2);
  // Popping at the last stop cycle chains frames with no idle gap.
  assign w_tx_pop = w_tx_en && !w_tx_empty && ((r_tx_state == c_st_idle) || w_tx_frame_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state    <= c_st_idle;
      r_tx_tmr      <= '0;
      r_tx_period   <= '0;
      r_tx_bit      <= '0;
      r_tx_shift    <= '0;
      r_tx_par_bit  <= 1'b0;
      r_tx_par_en   <= 1'b0;
      r_tx_two_stop <= 1'b0;
      r_tx_stop2    <= 1'b0;
      r_tx_pin      <= 1'b1;
    end else if (w_tx_pop) begin
      r_tx_state    <= c_st_start;
      r_tx_tmr      <= r_baud;
      r_tx_period   <= r_baud;
      r_tx_shift    <= w_tx_head;
      r_tx_par_bit  <= (^w_tx_head) ^ w_par_odd;
      r_tx_par_en   <= w_par_en;
      r_tx_two_stop <= r_ctrl[4];
      r_tx_stop2    <= 1'b0;
      r_tx_bit      <= '0;
      r_tx_pin      <= 1'b0;
    end else if (r_tx_state != c_st_idle) begin
      if (r_tx_tmr != 16'd0) begin
        r_tx_tmr <= r_tx_tmr - 16'd1;
      end else begin
        r_tx_tmr <= r_tx_period;
        case (r_tx_state)
          c_st_start: begin
            r_tx_state <= c_st_data;
            r_tx_pin   <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
          end
          c_st_data: begin
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= r_tx_par_en ? c_st_parity : c_st_stop;
              r_tx_pin   <= r_tx_par_en ? r_tx_par_bit : 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_pin   <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
            end
          end
          c_st_parity: begin
            r_tx_state <= c_st_stop;
            r_tx_pin   <= 1'b1;
          end
          default: begin
            if (r_tx_two_stop && !r_tx_stop2) r_tx_stop2 <= 1'b1;
            else                              r_tx_state <= c_st_idle;
          end
        endcase
      end
    end
  end

  // ---------------- RX synchroniser + FSM ----------------
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic [2:0]  r_rx_state;
  logic [15:0] r_rx_tmr, r_rx_period;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_par_en, r_rx_par_odd, r_rx_par_bit;
  logic        w_rx_fall, w_rx_done, w_rx_perr;

  assign w_rx_fall = r_rx_prev && !r_rx_s2;
  assign w_rx_done = w_rx_en && (r_rx_state == c_st_stop) && (r_rx_tmr == 16'd0);
  assign w_rx_perr = r_rx_par_en && (r_rx_par_bit != ((^r_rx_shift) ^ r_rx_par_odd));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx_pin;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state   <= c_st_idle;
      r_rx_tmr     <= '0;
      r_rx_period  <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_par_bit <= 1'b0;
    end else if (!w_rx_en) begin
      r_rx_state <= c_st_idle;
    end else if (r_rx_state == c_st_idle) begin
      if (w_rx_fall) begin
        r_rx_state   <= c_st_start;
        r_rx_tmr     <= r_baud >> 1;
        r_rx_period  <= r_baud;
        r_rx_par_en  <= w_par_en;
        r_rx_par_odd <= w_par_odd;
      end
    end else if (r_rx_tmr != 16'd0) begin
      r_rx_tmr <= r_rx_tmr - 16'd1;
    end else begin
      r_rx_tmr <= r_rx_period;
      case (r_rx_state)
        c_st_start: begin
          if (r_rx_s2) begin
            r_rx_state <= c_st_idle;
          end else begin
            r_rx_state <= c_st_data;
            r_rx_bit   <= '0;
          end
        end
        c_st_data: begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) r_rx_state <= r_rx_par_en ? c_st_parity : c_st_stop;
          else                  r_rx_bit   <= r_rx_bit + 3'd1;
        end
        c_st_parity: begin
          r_rx_par_bit <= r_rx_s2;
          r_rx_state   <= c_st_stop;
        end
        default: r_rx_state <= c_st_idle;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wp, r_rx_rp;
  logic [RX_AW:0]   r_rx_cnt;
  logic             w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_ovr;

  assign w_rx_full  = (r_rx_cnt == (RX_AW+1)'(RX_DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_pop   = re_i && (w_addr == c_addr_rxdata) && !w_rx_empty;
  assign w_rx_push  = w_rx_done && (!w_rx_full || w_rx_pop);
  assign w_rx_ovr   = w_rx_done && w_rx_full && !w_rx_pop;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + RX_AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_AW'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + (RX_AW+1)'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - (RX_AW+1)'(1);
    end
  end

  // ---------------- registers, sticky flags, IRQ ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl <= '0;
      r_baud <= BAUD_DEFAULT;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (we_i && w_addr == c_addr_ctrl) r_ctrl <= data_i[6:0];
      if (we_i && w_addr == c_addr_baud) r_baud <= data_i[15:0];
      // Hardware set takes priority over a same-cycle write-1-to-clear.
      r_perr <= (r_perr & ~w_clr[0]) | (w_rx_done & w_rx_perr);
      r_ferr <= (r_ferr & ~w_clr[1]) | (w_rx_done & ~r_rx_s2);
      r_ovr  <= (r_ovr  & ~w_clr[2]) | w_rx_ovr;
      r_irq  <= (r_ctrl[5] & ~w_rx_empty) | (r_ctrl[6] & w_tx_empty);
    end
  end

  logic [31:0] w_tx_lvl, w_rx_lvl, w_rdata;
  logic        w_tx_busy;

  assign w_tx_lvl  = 32'(r_tx_cnt);
  assign w_rx_lvl  = 32'(r_rx_cnt);
  assign w_tx_busy = (r_tx_state != c_st_idle) || !w_tx_empty;

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      c_addr_ctrl:   w_rdata = {25'h0, r_ctrl};
      c_addr_status: w_rdata = {25'h0, r_ovr, r_ferr, r_perr, w_rx_full, w_tx_full,
                               !w_rx_empty, w_tx_busy};
      c_addr_baud:   w_rdata = {16'h0, r_baud};
      c_addr_rxdata: w_rdata = w_rx_empty ? 32'h0 : {24'h0, r_rx_mem[r_rx_rp]};
      c_addr_level:  w_rdata = {8'h0, w_tx_lvl[7:0], 8'h0, w_rx_lvl[7:0]};
      default:       w_rdata = '0;
    endcase
  end

  assign data_o = rst ? w_rdata : 32'h0;
  assign irq_o  = r_irq;
  assign tx_pin = r_tx_pin;

  logic w_unused;
  assign w_unused = &{1'b0, addr_i[31:8], data_i[31:16], w_tx_lvl[31:8], w_rx_lvl[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`default_nettype none
// Bench for uart_fifo: register table, exact TX waveform, loopback/scoreboard, RX error and reset cases.
module tb_uart_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i, re_i;
  logic [31:0] addr_i, data_i, data_o;
  logic        irq_o, tx_pin, rx_pin;
  logic        loop, drv_rx;

  assign rx_pin = loop ? tx_pin : drv_rx;

  uart_fifo dut (
    .clk(clk), .rst(rst), .we_i(we_i), .re_i(re_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .irq_o(irq_o), .tx_pin(tx_pin), .rx_pin(rx_pin)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  bit         mon_on  = 1'b0;
  int         mon_p   = 4;
  int         mon_par = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    we_i = 1'b1; addr_i = {24'h0, a}; data_i = d;
    @(negedge clk);
    we_i = 1'b0; data_i = 32'h0;
  endtask

  task automatic rd(input logic [7:0] a, input bit pop, output logic [31:0] d);
    @(negedge clk);
    addr_i = {24'h0, a}; re_i = pop;
    #1 d = data_o;
    @(negedge clk);
    re_i = 1'b0;
  endtask

  task automatic wait_tx_idle(input int bound);
    logic [31:0] s;
    s = 32'h1;
    for (int i = 0; i < bound; i++) begin
      rd(8'h04, 1'b0, s);
      if (!s[0]) break;
    end
    chk("tx_idle_timeout", {31'h0, s[0]}, 32'h0);
  endtask

  // Bench-driven serial frame at 4 clocks per bit.
  task automatic send_rx(input logic [7:0] b, input bit has_par, input bit pbit, input bit stopb);
    @(negedge clk);
    drv_rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drv_rx = b[i];
      repeat (4) @(negedge clk);
    end
    if (has_par) begin
      drv_rx = pbit;
      repeat (4) @(negedge clk);
    end
    drv_rx = stopb;
    repeat (4) @(negedge clk);
    drv_rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Independent serial decoder on tx_pin; pops the scoreboard per frame.
  initial begin
    logic [7:0] b, e;
    logic       pb;
    forever begin
      @(negedge clk);
      if (mon_on && tx_pin === 1'b0) begin
        repeat (mon_p / 2) @(negedge clk);
        chk("mon_start_bit", {31'h0, tx_pin}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          repeat (mon_p) @(negedge clk);
          b[i] = tx_pin;
        end
        pb = 1'b0;
        if (mon_par != 0) begin
          repeat (mon_p) @(negedge clk);
          pb = tx_pin;
        end
        repeat (mon_p) @(negedge clk);
        chk("mon_stop_bit", {31'h0, tx_pin}, 32'h1);
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected_frame: got 0x%0h expected no frame", b);
        end else begin
          e = exp_tx.pop_front();
          chk("mon_tx_byte", {24'h0, b}, {24'h0, e});
          if (mon_par != 0)
            chk("mon_parity_bit", {31'h0, pb}, {31'h0, (^e) ^ (mon_par == 2)});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          do_wr;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] d;
    logic [7:0]  pat;
    logic        expbit;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,         8'h00, 32'h0,        "rst_ctrl"};
    vecs[1]  = '{1'b0, 8'h00, 32'h0,         8'h04, 32'h0,        "rst_status"};
    vecs[2]  = '{1'b0, 8'h00, 32'h0,         8'h08, 32'h1B8,      "rst_baud"};
    vecs[3]  = '{1'b0, 8'h00, 32'h0,         8'h14, 32'h0,        "rst_level"};
    vecs[4]  = '{1'b0, 8'h00, 32'h0,         8'h10, 32'h0,        "rst_rxdata_empty"};
    vecs[5]  = '{1'b0, 8'h00, 32'h0,         8'h18, 32'h0,        "unmapped_read"};
    vecs[6]  = '{1'b1, 8'h00, 32'hFFFFFF60,  8'h00, 32'h60,       "ctrl_write_mask"};
    vecs[7]  = '{1'b1, 8'h08, 32'hABCD1234,  8'h08, 32'h1234,     "baud_write_mask"};
    vecs[8]  = '{1'b1, 8'h18, 32'hFFFFFFFF,  8'h00, 32'h60,       "unmapped_write_ignored"};
    vecs[9]  = '{1'b1, 8'h04, 32'hFFFFFFFF,  8'h04, 32'h0,        "status_ro_bits"};
    vecs[10] = '{1'b1, 8'h0C, 32'h12,        8'h14, 32'h0,        "txdata_dropped_tx_dis"};
    vecs[11] = '{1'b1, 8'h00, 32'h0,         8'h00, 32'h0,        "ctrl_clear"};

    rst = 1'b0; we_i = 1'b0; re_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;
    loop = 1'b0; drv_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_pin", {31'h0, tx_pin}, 32'h1);
    chk("rst_irq", {31'h0, irq_o}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, 1'b0, d);
      chk(vecs[i].name, d, vecs[i].exp);
    end

    // IRQ: tx_ie with empty TX FIFO, one cycle after the CTRL write lands
    wr(8'h00, 32'h40);
    chk("irq_latency_0", {31'h0, irq_o}, 32'h0);
    @(negedge clk);
    chk("irq_tx_empty", {31'h0, irq_o}, 32'h1);
    wr(8'h00, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("irq_cleared", {31'h0, irq_o}, 32'h0);

    // Exact waveform of 0x55 at BAUD=3
    wr(8'h08, 32'h3);
    wr(8'h00, 32'h1);
    wr(8'h0C, 32'h55);
    pat = 8'h55;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 4)       expbit = 1'b0;
      else if (i < 36) expbit = pat[(i - 4) / 4];
      else             expbit = 1'b1;
      chk($sformatf("tx55_cycle%0d", i), {31'h0, tx_pin}, {31'h0, expbit});
    end
    @(negedge clk);
    rd(8'h04, 1'b0, d);
    chk("tx55_busy_done", {31'h0, d[0]}, 32'h0);

    // Loopback, even parity, 0xA7
    mon_p = 4; mon_par = 1; loop = 1'b1; mon_on = 1'b1;
    wr(8'h00, 32'h07);
    exp_tx.push_back(8'hA7);
    wr(8'h0C, 32'hA7);
    wait_tx_idle(100);
    repeat (10) @(negedge clk);
    rd(8'h04, 1'b0, d);
    chk("par_status", d, 32'h02);
    rd(8'h10, 1'b1, d);
    chk("par_rxdata", d, 32'hA7);
    mon_on = 1'b0; loop = 1'b0;

    // Bench-driven frames: bad parity, then bad stop
    wr(8'h00, 32'h06);
    exp_rx.push_back(8'h3C);
    send_rx(8'h3C, 1'b1, 1'b1, 1'b1);
    exp_rx.push_back(8'h5A);
    send_rx(8'h5A, 1'b1, 1'b0, 1'b0);
    rd(8'h04, 1'b0, d);
    chk("err_status", d, 32'h32);
    wr(8'h04, 32'h30);
    rd(8'h04, 1'b0, d);
    chk("err_w1c", d, 32'h02);
    rd(8'h14, 1'b0, d);
    chk("err_level", d, 32'h2);
    for (int i = 0; i < 2; i++) begin
      rd(8'h10, 1'b1, d);
      chk("err_rxdata", d, {24'h0, exp_rx.pop_front()});
    end

    // One-cycle glitch must not start a frame
    @(negedge clk);
    drv_rx = 1'b0;
    @(negedge clk);
    drv_rx = 1'b1;
    repeat (20) @(negedge clk);
    rd(8'h14, 1'b0, d);
    chk("glitch_level", d, 32'h0);
    rd(8'h04, 1'b0, d);
    chk("glitch_status", d, 32'h0);

    // Loopback fill: 10 writes -> 9 frames, 8 kept, overrun
    mon_par = 0; loop = 1'b1; mon_on = 1'b1;
    wr(8'h00, 32'h03);
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_tx.push_back(8'h10 + 8'(i));
      if (i < 8) exp_rx.push_back(8'h10 + 8'(i));
      wr(8'h0C, 32'h10 + i);
    end
    rd(8'h14, 1'b0, d);
    chk("fill_tx_level", d, 32'h00080000);
    rd(8'h04, 1'b0, d);
    chk("fill_tx_full", {28'h0, d[3:0]}, 32'h5);
    wait_tx_idle(400);
    repeat (20) @(negedge clk);
    rd(8'h04, 1'b0, d);
    chk("ovr_status", d, 32'h4A);
    rd(8'h14, 1'b0, d);
    chk("ovr_level", d, 32'h8);
    for (int i = 0; i < 8; i++) begin
      rd(8'h10, 1'b1, d);
      chk($sformatf("ovr_rxdata%0d", i), d, {24'h0, exp_rx.pop_front()});
    end
    rd(8'h10, 1'b1, d);
    chk("ovr_read_empty", d, 32'h0);
    chk("tx_queue_drained", exp_tx.size(), 32'h0);
    wr(8'h04, 32'h40);
    rd(8'h04, 1'b0, d);
    chk("ovr_w1c", d, 32'h0);
    mon_on = 1'b0; loop = 1'b0;

    // Async reset mid-frame
    wr(8'h00, 32'h41);
    wr(8'h0C, 32'h00);
    repeat (6) @(negedge clk);
    chk("pre_rst_tx_pin", {31'h0, tx_pin}, 32'h0);
    chk("pre_rst_irq", {31'h0, irq_o}, 32'h1);
    addr_i = 32'h08;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_tx_pin", {31'h0, tx_pin}, 32'h1);
    chk("rst_mid_irq", {31'h0, irq_o}, 32'h0);
    chk("rst_mid_data_o", data_o, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd(8'h14, 1'b0, d);
    chk("post_rst_level", d, 32'h0);
    rd(8'h08, 1'b0, d);
    chk("post_rst_baud", d, 32'h1B8);
    repeat (10) @(negedge clk);
    chk("post_rst_tx_idle", {31'h0, tx_pin}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
